// File: rtl/edge_buffer_reader_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Shared constants and FSM encoding for the edge-map read-side master.
//   NUM_PIXELS  : edge bits per frame (150x150 image)
//   ADDR_W      : pixel address width, 2**ADDR_W >= NUM_PIXELS
//   BYTE_W      : bits packed into each output word
//   FRAME_BYTES : output data words per frame, ceil(NUM_PIXELS/BYTE_W)
// Optional feature macro: READER_CHECKSUM_EN adds the CSUM state.
// ---------------------------------------------------------------------------
package edge_pkg;

  localparam int NUM_PIXELS  = 22500;
  localparam int ADDR_W      = 15;
  localparam int BYTE_W      = 8;
  localparam int FRAME_BYTES = (NUM_PIXELS + BYTE_W - 1) / BYTE_W;

`ifdef READER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PUSH  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PUSH  = 3'd2,
    DONE  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/edge_buffer_reader_if.sv
// ---------------------------------------------------------------------------
// edge_buffer_reader_if
// Bundles the store read port and the downstream byte link.
//   rd_en, rd_addr   : read strobe/address toward the edge-map store
//   rd_data          : edge bit returned one cycle after rd_en
//   byte_data        : packed output word, stable while byte_valid
//   byte_valid/ready : valid/ready handshake toward the byte link
// Modports: master = reader side, slave = store + downstream side.
// ---------------------------------------------------------------------------
interface edge_buffer_reader_if #(
  parameter int ADDR_W = edge_pkg::ADDR_W,
  parameter int BYTE_W = edge_pkg::BYTE_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output rd_en, rd_addr, byte_data, byte_valid,
    input  rd_data, byte_ready
  );

  modport slave (
    input  rd_en, rd_addr, byte_data, byte_valid,
    output rd_data, byte_ready
  );

endinterface

// File: rtl/edge_buffer_reader_bit_packer.sv
// ---------------------------------------------------------------------------
// bit_packer
// BYTE_W-bit shift-free packing register: each loaded bit lands at its own
// index, so bits may arrive in address order and the byte is LSB-first.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the register (start of a new byte)
//   load       : write bit_in into data[idx]
//   last       : the bit being loaded completes the current byte
//   data       : packed word
//   full       : byte is complete this cycle (load of its last bit)
// ---------------------------------------------------------------------------
module bit_packer #(
  parameter int BYTE_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  input  logic              bit_in,
  input  logic              last,
  output logic [BYTE_W-1:0] data,
  output logic              full
);

  // Clear has priority; the FSM never clears and loads in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (load) begin
      data[idx] <= bit_in;
    end
  end

  assign full = load & last;

endmodule

// File: rtl/edge_buffer_reader.sv
// ---------------------------------------------------------------------------
// edge_buffer_reader
// Read-side master for the 1-bit edge-map store. On start it walks pixel
// addresses 0..NUM_PIXELS-1, packs the returned bits LSB-first into words
// and hands each word downstream over valid/ready.
//   clk, reset : clock, asynchronous active-high reset
//   start      : 1-cycle pulse, begins a frame (ignored unless idle)
//   busy       : high from the cycle after start until the done cycle
//   done       : 1-cycle pulse after the final word transfer
//   bus        : edge_buffer_reader_if.master (store port + byte link)
// Optional feature macro: READER_CHECKSUM_EN appends an XOR checksum word.
// ---------------------------------------------------------------------------
module edge_buffer_reader #(
  parameter int NUM_PIXELS = edge_pkg::NUM_PIXELS,
  parameter int ADDR_W     = edge_pkg::ADDR_W,
  parameter int BYTE_W     = edge_pkg::BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  edge_buffer_reader_if.master  bus
);

  import edge_pkg::*;

  localparam int                IDX_W     = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTE_W - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  bit_idx;
  logic              byte_issued;
  logic              final_issued;
  logic              pend;
  logic              pend_last;
  logic [IDX_W-1:0]  pend_idx;
  logic              issue;
  logic              issue_last;
  logic              clear_pack;
  logic              byte_full;
  logic [BYTE_W-1:0] pack_data;

  // A read is issued every FETCH cycle until the current word has all its
  // addresses out; the frame's last address also closes a (short) word.
  assign issue      = (state == FETCH) && !byte_issued;
  assign issue_last = (bit_idx == LAST_IDX) || (addr == LAST_ADDR);
  assign clear_pack = ((state == IDLE) && start) || ((state == PUSH) && bus.byte_ready);

  bit_packer #(
    .BYTE_W (BYTE_W),
    .IDX_W  (IDX_W)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_pack),
    .load   (pend),
    .idx    (pend_idx),
    .bit_in (bus.rd_data),
    .last   (pend_last),
    .data   (pack_data),
    .full   (byte_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address walk plus the one-cycle delayed copy of the read strobe, which
  // tells the packer where the returning bit belongs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr         <= '0;
      bit_idx      <= '0;
      byte_issued  <= 1'b0;
      final_issued <= 1'b0;
      pend         <= 1'b0;
      pend_last    <= 1'b0;
      pend_idx     <= '0;
    end else begin
      pend      <= issue;
      pend_last <= issue_last;
      pend_idx  <= bit_idx;
      if (state == IDLE) begin
        addr         <= '0;
        bit_idx      <= '0;
        byte_issued  <= 1'b0;
        final_issued <= 1'b0;
      end else if (issue) begin
        if (addr == LAST_ADDR) begin
          final_issued <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
        bit_idx     <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
        byte_issued <= issue_last;
      end else if ((state == PUSH) && bus.byte_ready) begin
        byte_issued <= 1'b0;
      end
    end
  end

`ifdef READER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  // Running XOR of every data word actually handed downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (state == IDLE) begin
      csum <= '0;
    end else if ((state == PUSH) && bus.byte_ready) begin
      csum <= csum ^ pack_data;
    end
  end
`endif

  // Next state and all outputs come straight from the registered state, so
  // every output is zero while reset is held.
  always_comb begin
    state_next     = state;
    bus.rd_en      = issue;
    bus.rd_addr    = addr;
    bus.byte_valid = 1'b0;
    bus.byte_data  = pack_data;
    busy           = (state != IDLE);
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (byte_full) state_next = PUSH;
      end
      PUSH: begin
        bus.byte_valid = 1'b1;
        if (bus.byte_ready) begin
`ifdef READER_CHECKSUM_EN
          state_next = final_issued ? CSUM : FETCH;
`else
          state_next = final_issued ? DONE : FETCH;
`endif
        end
      end
`ifdef READER_CHECKSUM_EN
      CSUM: begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = csum;
        if (bus.byte_ready) state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_edge_buffer_reader.sv
// ---------------------------------------------------------------------------
// tb_edge_buffer_reader
// Directed bench for edge_buffer_reader. A behavioural store answers reads
// one cycle late from a selectable bit pattern; expected words are queued
// when a frame is started and popped as the DUT hands words downstream.
// Honours READER_CHECKSUM_EN (expects the extra XOR word when defined).
// ---------------------------------------------------------------------------
module tb_edge_buffer_reader;

  import edge_pkg::*;

`ifdef READER_CHECKSUM_EN
  localparam int FRAME_TOTAL = FRAME_BYTES + 1;
`else
  localparam int FRAME_TOTAL = FRAME_BYTES;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  edge_buffer_reader_if #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W)) bus ();

  edge_buffer_reader dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int pattern = 0;
  int byte_idx = 0;
  int exp_addr = 0;
  int max_addr = 0;
  int done_count = 0;
  logic [BYTE_W-1:0] exp_q[$];

  // Pattern 0: pixels 0, 2, 8 and the last four pixels set.
  // Pattern 1: every third pixel set.
  function automatic logic store_bit(input int a, input int p);
    if (p == 0) return (a == 0) || (a == 2) || (a == 8) || (a >= NUM_PIXELS - 4);
    return (a % 3) == 0;
  endfunction

  function automatic logic [BYTE_W-1:0] exp_byte(input int b, input int p);
    logic [BYTE_W-1:0] v;
    v = '0;
    for (int k = 0; k < BYTE_W; k++) begin
      if (b * BYTE_W + k < NUM_PIXELS) v[k] = store_bit(b * BYTE_W + k, p);
    end
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Edge-map store: registered read, data one cycle after rd_en.
  always @(posedge clk) begin
    bus.rd_data <= bus.rd_en ? store_bit(int'(bus.rd_addr), pattern) : 1'b0;
  end

  // Read-port monitor: sequential addresses, no reads during backpressure.
  always @(negedge clk) begin
    if (reset) begin
      exp_addr = 0;
      max_addr = 0;
    end else begin
      if (!busy) exp_addr = 0;
      if (done) done_count++;
      if (bus.rd_en) begin
        check_output("rd_addr_seq", 32'(bus.rd_addr), 32'(exp_addr));
        check_output("rd_en_while_valid", 32'(bus.byte_valid), 32'd0);
        if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
        exp_addr++;
      end
    end
  end

  // Pulse start at a negedge and queue the whole frame's expected words.
  task automatic apply_stimulus();
    logic [BYTE_W-1:0] b;
`ifdef READER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum;
    sum = '0;
`endif
    bus.byte_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      b = exp_byte(i, pattern);
      exp_q.push_back(b);
`ifdef READER_CHECKSUM_EN
      sum ^= b;
`endif
    end
`ifdef READER_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    byte_idx = 0;
    @(negedge clk);
    start = 1'b0;
    check_output("first_rd_en", 32'(bus.rd_en), 32'd1);
    check_output("first_rd_addr", 32'(bus.rd_addr), 32'd0);
    check_output("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Accept words with ready high until byte_idx reaches upto.
  task automatic consume(input int upto, input int budget);
    int cyc;
    cyc = 0;
    while (byte_idx < upto && cyc < budget) begin
      bus.byte_ready = 1'b1;
      if (bus.byte_valid) begin
        if (exp_q.size() == 0) begin
          check_output("byte_extra", 32'd1, 32'd0);
        end else begin
          check_output("byte_data", 32'(bus.byte_data), 32'(exp_q.pop_front()));
        end
        byte_idx++;
      end
      @(negedge clk);
      cyc++;
    end
    check_output("consume_progress", 32'(byte_idx), 32'(upto));
  endtask

  initial begin
    int done_before;
    int cyc;
    logic [BYTE_W-1:0] held;

    reset = 1'b1;
    start = 1'b0;
    bus.byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_rd_en", 32'(bus.rd_en), 32'd0);
    check_output("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
    check_output("reset_byte_data", 32'(bus.byte_data), 32'd0);
    check_output("reset_byte_valid", 32'(bus.byte_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: pattern 0, backpressure at word 3, stray start at word 10.
    $display("[TB] frame 1: full readout, pattern 0");
    pattern = 0;
    done_before = done_count;
    apply_stimulus();
    consume(3, 200);
    bus.byte_ready = 1'b0;
    cyc = 0;
    while (!bus.byte_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    held = bus.byte_data;
    for (int i = 0; i < 20; i++) begin
      check_output("stall_valid", 32'(bus.byte_valid), 32'd1);
      check_output("stall_data", 32'(bus.byte_data), 32'(held));
      check_output("stall_rd_en", 32'(bus.rd_en), 32'd0);
      @(negedge clk);
    end
    consume(10, 400);
    bus.byte_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    consume(FRAME_TOTAL, 40000);
    check_output("done_pulse", 32'(done), 32'd1);
    check_output("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("done_low_after", 32'(done), 32'd0);
    check_output("busy_low_after", 32'(busy), 32'd0);
    check_output("valid_low_after", 32'(bus.byte_valid), 32'd0);
    repeat (3) @(negedge clk);
    check_output("done_count_f1", 32'(done_count - done_before), 32'd1);
    check_output("queue_empty_f1", 32'(exp_q.size()), 32'd0);
    check_output("max_rd_addr", 32'(max_addr), 32'(NUM_PIXELS - 1));

    // Frame 2: pattern 1, reset asserted mid-frame at word 1000.
    $display("[TB] frame 2: reset abort at word 1000");
    pattern = 1;
    done_before = done_count;
    apply_stimulus();
    consume(1000, 12000);
    bus.byte_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_output("abort_rd_en", 32'(bus.rd_en), 32'd0);
    check_output("abort_rd_addr", 32'(bus.rd_addr), 32'd0);
    check_output("abort_byte_data", 32'(bus.byte_data), 32'd0);
    check_output("abort_byte_valid", 32'(bus.byte_valid), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_output("no_done_after_abort", 32'(done_count - done_before), 32'd0);

    // Frame 3: restart after abort reads again from address 0.
    $display("[TB] frame 3: restart after abort");
    apply_stimulus();
    consume(16, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
